// File: rtl/calc_pkg.sv
// Types and width helpers used by the calculator operation units.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    MUL   = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } ncr_state_e;

  typedef struct packed {
    logic err;
    logic ovf;
  } calc_status_t;

  localparam int N_W_DEF   = 8;
  localparam int RES_W_DEF = 32;

  // Room for a full result times the largest operand, so products never truncate.
  function automatic int acc_width(input int res_w, input int n_w);
    return res_w + n_w;
  endfunction

  localparam int ACC_W = acc_width(RES_W_DEF, N_W_DEF);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle: load -> W cycles -> done.
module seq_divider #(
  parameter int W   = 40,
  parameter int N_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   dividend,
  input  logic [N_W-1:0] divisor,
  output logic [W-1:0]   quotient,
  output logic           done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N_W-1:0] rem;
  logic [W-1:0]   quo;
  logic [N_W-1:0] dvs;
  logic [CW-1:0]  cnt;

  // The remainder stays below the divisor, so the difference fits in N_W bits.
  function automatic logic [N_W+W-1:0] div_step(input logic [N_W-1:0] rem_in,
                                                 input logic [W-1:0]   quo_in,
                                                 input logic [N_W-1:0] d);
    logic [N_W:0]   trial;
    logic [N_W-1:0] diff;
    trial = {rem_in, quo_in[W-1]};
    diff  = trial[N_W-1:0] - d;
    if (trial >= {1'b0, d}) begin
      div_step = {diff, quo_in[W-2:0], 1'b1};
    end else begin
      div_step = {trial[N_W-1:0], quo_in[W-2:0], 1'b0};
    end
  endfunction

  assign quotient = quo;

  // The load cycle already performs the first step, so W-1 steps remain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= {N_W{1'b0}};
      quo  <= {W{1'b0}};
      dvs  <= {N_W{1'b0}};
      cnt  <= {CW{1'b0}};
      done <= 1'b0;
    end else if (load) begin
      {rem, quo} <= div_step({N_W{1'b0}}, dividend, divisor);
      dvs        <= divisor;
      cnt        <= CNT_INIT;
      done       <= 1'b0;
    end else if (cnt != {CW{1'b0}}) begin
      {rem, quo} <= div_step(rem, quo, dvs);
      cnt        <= cnt - CNT_ONE;
      done       <= (cnt == CNT_ONE);
    end
  end

endmodule

// File: rtl/ncr_seq_engine.sv
// Iterative nCr engine (nPr as well when NPR_MODE_EN is defined); every partial product is exact.
module ncr_seq_engine
  import calc_pkg::*;
#(
  parameter int N_W   = 8,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic [N_W-1:0]   r,
`ifdef NPR_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             valid,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic             ovf
);

  localparam int AW = acc_width(RES_W, N_W);
  localparam logic [N_W-1:0] ONE_N = {{(N_W-1){1'b0}}, 1'b1};

  ncr_state_e     state;
  calc_status_t   status;
  logic [N_W-1:0] n_q, r_q, k_q, base_q, i_q;
  logic [N_W-1:0] n_minus_r, k_calc, factor;
  logic [AW-1:0]  acc, product, quo;
  logic           npr, div_load, div_done;

`ifdef NPR_MODE_EN
  logic mode_q;
  assign npr = mode_q;
`else
  assign npr = 1'b0;
`endif

  assign err = status.err;
  assign ovf = status.ovf;

  // Iteration count and the next multiplier (n-k+i) for the running product.
  always_comb begin
    n_minus_r = n_q - r_q;
    k_calc    = r_q;
    if (!npr && (n_minus_r < r_q)) begin
      k_calc = n_minus_r;
    end else begin
      k_calc = r_q;
    end
    factor   = base_q + i_q;
    product  = acc * {{(AW-N_W){1'b0}}, factor};
    div_load = (state == MUL) && !npr;
  end

  seq_divider #(.W(AW), .N_W(N_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (product),
    .divisor  (i_q),
    .quotient (quo),
    .done     (div_done)
  );

  // Sequencer; busy drops in the IDLE cycle that carries the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      status <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= {RES_W{1'b0}};
      n_q    <= {N_W{1'b0}};
      r_q    <= {N_W{1'b0}};
      k_q    <= {N_W{1'b0}};
      base_q <= {N_W{1'b0}};
      i_q    <= {N_W{1'b0}};
      acc    <= {AW{1'b0}};
`ifdef NPR_MODE_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start && !busy) begin
            n_q    <= n;
            r_q    <= r;
`ifdef NPR_MODE_EN
            mode_q <= mode;
`endif
            status <= '0;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          acc <= {{(AW-1){1'b0}}, 1'b1};
          i_q <= ONE_N;
          if (r_q > n_q) begin
            status.err <= 1'b1;
            state      <= DONE;
          end else begin
            k_q    <= k_calc;
            base_q <= n_q - k_calc;
            state  <= (k_calc == {N_W{1'b0}}) ? DONE : MUL;
          end
        end
        MUL: begin
          acc <= product;
          if (!npr) begin
            state <= DIV;
          end else if (|product[AW-1:RES_W]) begin
            status.ovf <= 1'b1;
            state      <= DONE;
          end else if (i_q == k_q) begin
            state <= DONE;
          end else begin
            i_q <= i_q + ONE_N;
          end
        end
        DIV: begin
          // Partial binomials only grow, so the first oversize quotient settles the overflow.
          if (div_done) begin
            if (|quo[AW-1:RES_W]) begin
              status.ovf <= 1'b1;
              state      <= DONE;
            end else begin
              acc <= quo;
              if (i_q == k_q) begin
                state <= DONE;
              end else begin
                i_q   <= i_q + ONE_N;
                state <= MUL;
              end
            end
          end
        end
        DONE: begin
          valid <= 1'b1;
          if (status.err) begin
            result <= {RES_W{1'b0}};
          end else if (status.ovf) begin
            result <= {RES_W{1'b1}};
          end else begin
            result <= acc[RES_W-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncr_seq_engine.sv
// Directed and randomized checks of ncr_seq_engine against a Pascal-triangle reference (NPR_MODE_EN adds nPr cases).
module tb_ncr_seq_engine;

  localparam int N_W   = 8;
  localparam int RES_W = 32;
  localparam int ACC_W = N_W + RES_W;
  localparam longint MAXV = (64'd1 << RES_W) - 64'd1;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [N_W-1:0]   n, r;
  logic             busy, valid, err, ovf;
  logic [RES_W-1:0] result;
`ifdef NPR_MODE_EN
  logic             mode;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ncr_seq_engine #(.N_W(N_W), .RES_W(RES_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n),
    .r      (r),
`ifdef NPR_MODE_EN
    .mode   (mode),
`endif
    .busy   (busy),
    .valid  (valid),
    .result (result),
    .err    (err),
    .ovf    (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Binomial from Pascal's rule, clamped just above the representable maximum.
  function automatic longint ref_ncr(input int nn, input int rr);
    longint row [0:255];
    for (int j = 0; j < 256; j++) row[j] = 0;
    row[0] = 1;
    for (int m = 1; m <= nn; m++) begin
      for (int j = m; j >= 1; j--) begin
        row[j] = row[j] + row[j-1];
        if (row[j] > MAXV + 1) row[j] = MAXV + 1;
      end
    end
    return row[rr];
  endfunction

  task automatic run_op(input int nn, input int rr, input bit m, input int inject_at,
                        input bit pulse_after, input string tag);
    longint v, er;
    bit     ee, eo, seen, gap, extra;
    int     elat, maxlat, lat, k;
    ee = 1'b0; eo = 1'b0; v = 0; elat = 2; maxlat = 2;
    if (rr > nn) begin
      ee = 1'b1;
    end else if (m) begin
      v = 1;
      for (int i = 1; i <= rr; i++) begin
        v = v * (nn - rr + i);
        if (v > MAXV) begin eo = 1'b1; break; end
      end
      maxlat = 2 + rr;
      elat   = eo ? -1 : maxlat;
    end else begin
      v      = ref_ncr(nn, rr);
      eo     = (v > MAXV);
      k      = (rr < nn - rr) ? rr : nn - rr;
      maxlat = 2 + k * (1 + ACC_W);
      elat   = eo ? -1 : maxlat;
    end
    er = ee ? 0 : (eo ? MAXV : v);

    @(negedge clk);
    n = N_W'(nn); r = N_W'(rr); start = 1'b1;
`ifdef NPR_MODE_EN
    mode = m;
`endif
    @(posedge clk); #1;
    start = 1'b0; n = N_W'($urandom); r = N_W'($urandom);
`ifdef NPR_MODE_EN
    mode = 1'($urandom);
`endif
    lat = 0; seen = 1'b0; gap = 1'b0;
    while (!seen && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
      if (lat == inject_at) begin
        start = 1'b1; n = 8'd3; r = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (!busy) gap = 1'b1;
      if (valid) seen = 1'b1;
    end
    check({tag, "/valid_seen"}, 64'(seen), 64'd1);
    check({tag, "/result"}, 64'(result), 64'(er));
    check({tag, "/err"}, 64'(err), 64'(ee));
    check({tag, "/ovf"}, 64'(ovf), 64'(eo));
    if (elat >= 0) check({tag, "/latency"}, 64'(lat), 64'(elat));
    else           check({tag, "/latency_bound"}, 64'(lat >= 2 && lat <= maxlat), 64'd1);
    check({tag, "/busy_held"}, 64'(gap), 64'd0);

    if (pulse_after) begin
      start = 1'b1; n = 8'd2; r = 8'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/valid_one_cycle"}, 64'(valid), 64'd0);
    check({tag, "/result_hold"}, 64'(result), 64'(er));
    extra = 1'b0;
    repeat (3) begin
      if (busy || valid) extra = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "/idle_after"}, 64'(extra), 64'd0);
  endtask

  initial begin
    bit stray;
    int nn, rr;
    bit m;
    rst = 1'b1; start = 1'b0; n = '0; r = '0;
`ifdef NPR_MODE_EN
    mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/valid", 64'(valid), 64'd0);
    check("reset/result", 64'(result), 64'd0);
    check("reset/err", 64'(err), 64'd0);
    check("reset/ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    run_op(10, 3, 1'b0, 0, 1'b0, "n10r3");
    run_op(5, 0, 1'b0, 0, 1'b0, "n5r0");
    run_op(7, 7, 1'b0, 0, 1'b0, "n7r7");
    run_op(0, 0, 1'b0, 0, 1'b0, "n0r0");
    run_op(3, 5, 1'b0, 0, 1'b1, "n3r5_err");
    run_op(6, 2, 1'b0, 0, 1'b0, "n6r2");
    run_op(60, 30, 1'b0, 0, 1'b0, "n60r30_ovf");
    run_op(34, 17, 1'b0, 0, 1'b0, "n34r17");
    run_op(9, 4, 1'b0, 20, 1'b0, "n9r4_busy_start");

    // Reset together with a start request in the middle of an operation.
    @(negedge clk);
    n = 8'd20; r = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; n = 8'd4; r = 8'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("midrst/busy", 64'(busy), 64'd0);
    check("midrst/valid", 64'(valid), 64'd0);
    check("midrst/result", 64'(result), 64'd0);
    check("midrst/err", 64'(err), 64'd0);
    check("midrst/ovf", 64'(ovf), 64'd0);
    stray = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (valid || busy) stray = 1'b1;
    end
    check("midrst/no_valid", 64'(stray), 64'd0);
    run_op(6, 2, 1'b0, 0, 1'b0, "after_rst_n6r2");

`ifdef NPR_MODE_EN
    run_op(5, 2, 1'b1, 0, 1'b0, "npr_n5r2");
    run_op(20, 20, 1'b1, 0, 1'b0, "npr_n20r20_ovf");
    run_op(10, 0, 1'b1, 0, 1'b0, "npr_n10r0");
    run_op(4, 6, 1'b1, 0, 1'b0, "npr_err");
`endif

    for (int t = 0; t < 16; t++) begin
      if (t % 4 == 3) begin
        nn = $urandom_range(200, 255);
        rr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : nn - $urandom_range(0, 3);
      end else begin
        nn = $urandom_range(0, 36);
        rr = $urandom_range(0, nn + 2);
      end
      m = 1'b0;
`ifdef NPR_MODE_EN
      m = 1'($urandom);
      if (m && rr > 12) rr = $urandom_range(0, 12);
`endif
      run_op(nn, rr, m, 0, 1'b0, $sformatf("rand%0d_n%0d_r%0d_m%0d", t, nn, rr, m));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
